// File: rtl/register_serial_reader_8bit_pkg.sv
// register_serial_reader_8bit_pkg: shared state encoding and defaults for the serial reader
package register_serial_reader_8bit_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam int DEFAULT_WIDTH = 8;
  localparam int CLOCK_PERIOD_HALF = 5;
endpackage

// File: rtl/register_serial_reader_8bit_if.sv
// register_serial_reader_8bit_if: parallel load strobe in, serial stream and handshake out
interface register_serial_reader_8bit_if #(parameter int WIDTH = register_serial_reader_8bit_pkg::DEFAULT_WIDTH);
  logic             loadbar;
  logic [WIDTH-1:0] data;
  logic             serial_out;
  logic             out_valid;
  logic             busy;
  logic             done;
  modport master (output loadbar, data, input serial_out, out_valid, busy, done);
  modport slave  (input loadbar, data, output serial_out, out_valid, busy, done);
endinterface

// File: rtl/register_serial_reader_8bit_bit_counter.sv
// register_serial_reader_8bit_bit_counter: up-counter with clear, flags the last bit of a word
module register_serial_reader_8bit_bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [CW-1:0] count;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= count + 1'b1;
  assign tc = count == CW'(WIDTH - 1);
endmodule

// File: rtl/register_serial_reader_8bit.sv
// register_serial_reader_8bit: captures a word on active-low load and streams it out serially
module register_serial_reader_8bit
  import register_serial_reader_8bit_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                          clk,
  input logic                          rst,
  register_serial_reader_8bit_if.slave bus
);
  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic             load, clr, en, tc;
  // X/Z on loadbar makes load non-true, so the if below falls to the no-load branch
  assign load = bus.loadbar == 1'b0;
  register_serial_reader_8bit_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .tc(tc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
    end
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    clr     = 1'b0;
    en      = 1'b0;
    case (state)
      SHIFT: begin
        en      = 1'b1;
        sreg_n  = MSB_FIRST ? sreg << 1 : sreg >> 1;
        state_n = tc ? DONE : SHIFT;
      end
      IDLE, DONE: begin
        if (load) begin
          state_n = SHIFT;
          sreg_n  = bus.data;
          clr     = 1'b1;
        end else state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  assign bus.out_valid  = state == SHIFT;
  assign bus.busy       = state == SHIFT;
  assign bus.done       = state == DONE;
  assign bus.serial_out = bus.out_valid & (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
endmodule

// File: tb/tb_register_serial_reader_8bit.sv
// tb_register_serial_reader_8bit: scoreboard bench driving MSB-first and LSB-first readers in parallel
module tb_register_serial_reader_8bit;
  import register_serial_reader_8bit_pkg::*;
  localparam int W = DEFAULT_WIDTH;
  typedef struct {int c; logic b;} ent_t;
  logic clk = 1'b0, rst = 1'b0, lb = 1'b1;
  logic [W-1:0] dat = '0;
  register_serial_reader_8bit_if #(W) bm (), bl ();
  assign bm.loadbar = lb;
  assign bm.data    = dat;
  assign bl.loadbar = lb;
  assign bl.data    = dat;
  register_serial_reader_8bit #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(bm));
  register_serial_reader_8bit #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(bl));
  always #CLOCK_PERIOD_HALF clk = ~clk;
  int checks = 0, errors = 0, cyc = 0, next_free = 0;
  ent_t qm[$], ql[$], em, el;
  int dqm[$], dql[$];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", n, a, e, cyc);
    end
  endtask
  task automatic fail(input string n);
    checks++;
    errors++;
    $display("FAIL %s: unexpected output at cycle %0d, nothing expected", n, cyc);
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_msb_serial"}, bm.serial_out, 0);
    chk({n, "_msb_valid"}, bm.out_valid, 0);
    chk({n, "_msb_busy"}, bm.busy, 0);
    chk({n, "_msb_done"}, bm.done, 0);
    chk({n, "_lsb_serial"}, bl.serial_out, 0);
    chk({n, "_lsb_valid"}, bl.out_valid, 0);
    chk({n, "_lsb_busy"}, bl.busy, 0);
    chk({n, "_lsb_done"}, bl.done, 0);
  endtask
  // Reference: a load is taken at any edge with a clean 0 once the previous word (W bits + done) is over
  always @(posedge clk) if (!rst) begin
    cyc++;
    if (lb === 1'b0 && cyc >= next_free) begin
      next_free = cyc + W + 1;
      for (int i = 0; i < W; i++) begin
        qm.push_back('{cyc + i, dat[W-1-i]});
        ql.push_back('{cyc + i, dat[i]});
      end
      dqm.push_back(cyc + W);
      dql.push_back(cyc + W);
    end
  end
  always @(negedge clk) if (!rst) begin
    if (bm.out_valid) begin
      if (qm.size() == 0) fail("msb_extra_bit");
      else begin
        em = qm.pop_front();
        chk("msb_bit_cycle", cyc, em.c);
        chk("msb_bit", bm.serial_out, em.b);
        chk("msb_busy_shift", bm.busy, 1);
      end
    end else begin
      chk("msb_idle_serial", bm.serial_out, 0);
      chk("msb_idle_busy", bm.busy, 0);
    end
    if (bm.done) begin
      if (dqm.size() == 0) fail("msb_extra_done");
      else chk("msb_done_cycle", cyc, dqm.pop_front());
    end
  end
  always @(negedge clk) if (!rst) begin
    if (bl.out_valid) begin
      if (ql.size() == 0) fail("lsb_extra_bit");
      else begin
        el = ql.pop_front();
        chk("lsb_bit_cycle", cyc, el.c);
        chk("lsb_bit", bl.serial_out, el.b);
        chk("lsb_busy_shift", bl.busy, 1);
      end
    end else begin
      chk("lsb_idle_serial", bl.serial_out, 0);
      chk("lsb_idle_busy", bl.busy, 0);
    end
    if (bl.done) begin
      if (dql.size() == 0) fail("lsb_extra_done");
      else chk("lsb_done_cycle", cyc, dql.pop_front());
    end
  end
  task automatic load(input logic [W-1:0] d);
    lb  = 1'b0;
    dat = d;
    @(negedge clk);
    lb  = 1'b1;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic async_reset(input string n);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_zero(n);
    qm.delete();
    ql.delete();
    dqm.delete();
    dql.delete();
    next_free = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    #1 rst = 1'b1;
    #1 chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    load(8'b10101010);
    idle(12);
    load(8'b11110000);
    idle(12);
    lb  = 1'b0;
    dat = 8'hFF;
    @(negedge clk);
    dat = 8'h00;
    idle(9);
    lb  = 1'b1;
    idle(12);
    load(8'hA5);
    idle(2);
    lb  = 1'b0;
    dat = 8'h00;
    @(negedge clk);
    lb  = 1'b1;
    idle(12);
    lb = 1'bx;
    idle(5);
    lb = 1'bz;
    idle(3);
    lb = 1'b1;
    idle(3);
    load(8'hFF);
    idle(4);
    chk("pre_reset_valid", bm.out_valid, 1);
    async_reset("reset_mid_word");
    idle(12);
    repeat (400) begin
      lb  = $urandom_range(0, 3) == 0;
      dat = W'($urandom);
      @(negedge clk);
    end
    lb = 1'b1;
    idle(12);
    chk("msb_bits_left", qm.size(), 0);
    chk("lsb_bits_left", ql.size(), 0);
    chk("msb_done_left", dqm.size(), 0);
    chk("lsb_done_left", dql.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
